// File: rtl/bs_sat_rnd.sv
// Round-half-up / saturate stage for the barrel-shift flag word, 2-stage req/ack pipeline.
// Optional saturation event counter enabled by defining BS_SAT_CNT_EN.
module bs_sat_rnd #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH+3:0] t_0_dat,
    input  logic                  t_0_req,
    output logic                  t_0_ack,
    output logic [DATA_WIDTH-1:0] i_0_dat,
    output logic                  i_0_sat,
    output logic                  i_0_req,
    input  logic                  i_0_ack,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  sat_cnt
);

    localparam logic [DATA_WIDTH-1:0] MaxVal = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MinP1  = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    logic                  s1_v;
    logic [DATA_WIDTH:0]   s1_sum;
    logic                  s1_nflag;
    logic                  s1_pre_sat;
    logic                  s1_sign;
    logic                  s2_v;
    logic [DATA_WIDTH-1:0] s2_dat;
    logic                  s2_sat;

    logic                  s1_adv;
    logic                  s2_adv;
    logic [DATA_WIDTH:0]   sum_d;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] res_d;
    logic                  sat_d;

    assign s2_adv  = ~s2_v | i_0_ack;
    assign s1_adv  = ~s1_v | s2_adv;
    assign t_0_ack = s1_adv;

    assign sum_d = {t_0_dat[DATA_WIDTH-1], t_0_dat[DATA_WIDTH-1:0]}
                 + {{DATA_WIDTH{1'b0}}, t_0_dat[DATA_WIDTH+1]};
    assign ovf   = s1_sum[DATA_WIDTH] ^ s1_sum[DATA_WIDTH-1];

    always_comb begin
        res_d = s1_sum[DATA_WIDTH-1:0];
        sat_d = 1'b0;
        if (s1_pre_sat) begin
            res_d = s1_sign ? MinVal : MaxVal;
            sat_d = 1'b1;
        end else if (ovf) begin
            res_d = MaxVal;
            sat_d = 1'b1;
        end
        // Symmetric range: MIN is never emitted when nflag is set.
        if (s1_nflag && (res_d == MinVal)) begin
            res_d = MinP1;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            s2_dat <= '0;
            s2_sat <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v <= t_0_req;
                if (t_0_req) begin
                    s1_sum     <= sum_d;
                    s1_nflag   <= t_0_dat[DATA_WIDTH+3];
                    s1_pre_sat <= t_0_dat[DATA_WIDTH+2];
                    s1_sign    <= t_0_dat[DATA_WIDTH];
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_dat <= res_d;
                    s2_sat <= sat_d;
                end
            end
        end
    end

    assign i_0_req = s2_v;
    assign i_0_dat = s2_dat;
    assign i_0_sat = s2_sat;

`ifdef BS_SAT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (s2_v && i_0_ack && s2_sat && !(&cnt_q)) begin
            cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign sat_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sat_cnt        = '0;
`endif

endmodule
